// File: rtl/kitchen_emulator_if.sv
// Command/feedback link between a kitchen controller (master) and the emulator (slave).
interface kitchen_emulator_if;
    logic [7:0] in_bits;
    logic [7:0] out_bits;

    modport master (output in_bits, input  out_bits);
    modport slave  (input  in_bits, output out_bits);
endinterface

// File: rtl/kitchen_emulator.sv
// Behavioural stand-in for the PC-side kitchen game: decodes command words and
// keeps game, position, held item and per-machine processing state.
module kitchen_emulator #(
    parameter int MOVE_CYCLES    = 8,
    parameter int PROCESS_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    kitchen_emulator_if.slave  link
);
    localparam int NM = 6;
    localparam int MW = $clog2(MOVE_CYCLES + 1);
    localparam int PW = $clog2(PROCESS_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_END} state_t;

    state_t                 state_q, state_d;
    logic [4:0]             pos_q, pos_d, sel_q, sel_d;
    logic                   hold_q, hold_d;
    logic [MW-1:0]          mv_cnt_q, mv_cnt_d;
    logic [NM-1:0]          item_q, item_d, done_q, done_d;
    logic [NM-1:0][PW-1:0]  busy_q, busy_d;
    logic [7:0]             prev_q, prev_d;

    logic [1:0] cmd;
    logic [5:0] arg;
    logic       g_start, g_end, is_sel;
    logic       op_get, op_put, op_int, op_move, op_throw;
    logic       changed, at_sel, sel_mach, sel_disp, sel_item, sel_ready;
    logic [2:0] idx;

    assign cmd      = link.in_bits[1:0];
    assign arg      = link.in_bits[7:2];
    assign g_start  = (cmd == 2'b01) && (link.in_bits[3:2] == 2'b01);
    assign g_end    = (cmd == 2'b01) && (link.in_bits[3:2] == 2'b10);
    assign is_sel   = (cmd == 2'b11) && (arg != 6'd0) && (arg <= 6'd20);
    assign op_get   = (cmd == 2'b10) && (arg == 6'b000001);
    assign op_put   = (cmd == 2'b10) && (arg == 6'b000010);
    assign op_int   = (cmd == 2'b10) && (arg == 6'b000100);
    assign op_move  = (cmd == 2'b10) && (arg == 6'b001000);
    assign op_throw = (cmd == 2'b10) && (arg == 6'b010000);
    assign changed  = (link.in_bits != prev_q);

    assign at_sel    = (pos_q == sel_q);
    assign sel_mach  = (sel_q >= 5'd1) && (sel_q <= 5'd6);
    assign sel_disp  = (sel_q >= 5'd7) && (sel_q <= 5'd19);
    assign idx       = sel_mach ? (sel_q[2:0] - 3'd1) : 3'd0;
    assign sel_item  = sel_mach ? item_q[idx] : sel_disp;
    assign sel_ready = sel_mach ? done_q[idx] : 1'b1;

    assign link.out_bits = (state_q == ST_RUN) ?
        {2'b00, sel_item, sel_ready, hold_q, at_sel && (mv_cnt_q == '0), 1'b0, 1'b1} :
        8'h00;

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        sel_d    = sel_q;
        hold_d   = hold_q;
        mv_cnt_d = mv_cnt_q;
        item_d   = item_q;
        done_d   = done_q;
        prev_d   = link.in_bits;
        // Machines keep processing regardless of what command arrives this cycle.
        for (int i = 0; i < NM; i++) begin
            busy_d[i] = busy_q[i];
            if (busy_q[i] != '0) begin
                busy_d[i] = busy_q[i] - PW'(1);
                if (busy_q[i] == PW'(1)) done_d[i] = 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (g_start) begin
                    state_d  = ST_RUN;
                    pos_d    = 5'd1;
                    sel_d    = 5'd1;
                    hold_d   = 1'b0;
                    mv_cnt_d = '0;
                    item_d   = '0;
                    done_d   = '0;
                    busy_d   = '0;
                end
            end
            ST_RUN: begin
                mv_cnt_d = '0;
                if (g_end) begin
                    state_d = ST_END;
                end else if (is_sel) begin
                    sel_d = arg[4:0];
                end else if (op_move && !at_sel) begin
                    if (mv_cnt_q == MW'(MOVE_CYCLES - 1)) pos_d = sel_q;
                    else mv_cnt_d = mv_cnt_q + MW'(1);
                end else if (op_get) begin
                    if (at_sel && !hold_q && sel_item) begin
                        hold_d = 1'b1;
                        if (sel_mach) begin
                            item_d[idx] = 1'b0;
                            done_d[idx] = 1'b0;
                        end
                    end
                end else if ((op_put && at_sel && hold_q) || (op_throw && hold_q)) begin
                    // Landing on a full machine, dispenser or bin discards the item.
                    hold_d = 1'b0;
                    if (sel_mach && !item_q[idx]) begin
                        item_d[idx] = 1'b1;
                        done_d[idx] = 1'b0;
                    end
                end else if (op_int && changed) begin
                    if (at_sel && sel_mach && item_q[idx] && (busy_q[idx] == '0) && !done_q[idx])
                        busy_d[idx] = PW'(PROCESS_CYCLES);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pos_q    <= '0;
            sel_q    <= '0;
            hold_q   <= 1'b0;
            mv_cnt_q <= '0;
            item_q   <= '0;
            done_q   <= '0;
            busy_q   <= '0;
            prev_q   <= '0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            sel_q    <= sel_d;
            hold_q   <= hold_d;
            mv_cnt_q <= mv_cnt_d;
            item_q   <= item_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            prev_q   <= prev_d;
        end
    end
endmodule

// File: doc/kitchen_emulator.md
# kitchen_emulator

Behavioural responder for the kitchen game link: consumes the 8-bit command word that the manual and automatic controllers drive, and returns the 8-bit feedback word they poll. It models game state, player position and walking time, the held item, machine processing and target item presence, so the script executor can be exercised on-board or in simulation without the PC-side game.

## Interface
- MOVE_CYCLES, 8: cycles of a held move command needed to reach the selected target (≥1).
- PROCESS_CYCLES, 16: cycles a machine takes after interact before it is ready (≥1).
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_bits  input  8  command word from controller.
- out_bits  output  8  feedback word to controller.

## Operation
- One clock; reset is asynchronous and active-high.
- Command decode on in_bits[1:0]: 01 = game command (in_bits[3:2]: 01 start, 10 end, else none); 10 = operation (in_bits[7:2] one-hot: bit2 get, bit3 put, bit4 interact, bit5 move, bit6 throw; zero or multi-hot = no-op); 11 = target select, target = in_bits[7:2]; 00 = idle.
- Targets: 1..6 machines, 7..19 dispensers (always hold an item), 20 bin. Select of 0 or >20 ignored, sel unchanged.
- Game FSM: IDLE -> RUNNING on start; RUNNING -> ENDED on end; ENDED terminal until rst. Start outside IDLE ignored. All non-game commands ignored outside RUNNING.
- On IDLE->RUNNING: pos=1, sel=1, holding=0, machine state cleared.
- Select to t≠pos: sel=t, move counter cleared. Select to t==pos: sel=t only.
- Move: each cycle move is present and pos≠sel, counter increments; when it reaches MOVE_CYCLES, pos=sel, counter=0. Any other command cycle clears the counter.
- Get (level): pos==sel, !holding, has_item(sel) -> holding=1; on machine also clears has_item and done.
- Put (level): pos==sel, holding -> holding=0; on machine with !has_item sets has_item, clears done; on dispenser/bin item discarded.
- Throw (level): holding -> holding=0 regardless of pos; landing rules same as put; machine already holding item -> item discarded.
- Interact (acts only on the cycle in_bits differs from previous cycle's value): pos==sel, sel a machine, has_item, not busy, not done -> start busy counter at PROCESS_CYCLES.
- Busy counter per machine (6 counters, 5+ bits) decrements each cycle; on reaching 0 sets done.
- Feedback: [0] game running; [1] 0; [2] pos==sel and move counter 0; [3] holding; [4] target ready: sel machine ? done : 1; [5] has_item(sel): dispenser 1, bin 0, machine flag; [7:6] 0. All bits 0 when not RUNNING.

## Timing
- rst: FSM IDLE, pos=sel=0, holding=0, all machine flags/counters 0, out_bits=8'h00 immediately (async).
- out_bits is registered-state decode: effects of a command cycle n visible at out_bits after edge n (cycle n+1).
- Start at edge n -> out_bits=8'h0D? no: out_bits[0]=1,[2]=1,[4]=1 (machine 1 not done -> [4]=0), so out_bits=8'h05 from cycle n+1.
- Move latency: MOVE_CYCLES consecutive move cycles, [2] rises the cycle after the last.
- Interact at edge n -> [4] rises after edge n+PROCESS_CYCLES.
- Simultaneous events: one command per cycle by construction; busy counters run concurrently with any command.
- Reselecting during move aborts it; reselecting while machine busy does not stop processing.
- rst mid-operation discards everything; in_bits held at start after rst deassert starts the game on the next edge.

## Test plan
- rst, then in_bits=8'h05 one cycle -> out_bits 8'h00 then 8'h05; second start ignored; 8'h09 -> out_bits 8'h00 permanently.
- Running, select 7 (8'h1F), move 8'h22 for 8 cycles -> [2] low for 8 cycles, rises cycle 9; out_bits=8'h35.
- At 7 get 8'h06 -> [3]=1; select 3, move, put 8'h0A -> [3]=0, [5]=1, [4]=0.
- At 3, interact 8'h12 held 5 cycles -> single start; [4] rises exactly 16 cycles after first interact edge; get -> [3]=1,[5]=0,[4]=0.
- Holding, select 20 (8'h53), throw 8'h42 without moving -> [3]=0, [5]=0; select 0 and 8'h FF-style multi-hot op ignored.
- Assert rst mid-move and during machine busy -> out_bits 8'h00 asynchronously, busy state gone after restart.
